aha_sleep_controller: RTL

AHA_SLEEP_CONTROLLER -- requirements
Module: aha_sleep_controller

---
 rtl/aha_sleep_ctrl_pkg.sv | 54 +++++
 rtl/aha_reset_pulse_stretch.sv | 82 ++++++++
 rtl/aha_sleep_controller.sv | 105 ++++++++++
 3 files changed

// File: rtl/aha_sleep_ctrl_pkg.sv
// Shared definitions for the sleep controller: state encoding, reset-cause codes,
// counter width and the per-state output decode.
package aha_sleep_ctrl_pkg;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [2:0] ENC_RUN     = 3'd0;
  localparam logic [2:0] ENC_WIC_REQ = 3'd1;
  localparam logic [2:0] ENC_HOLD    = 3'd2;
  localparam logic [2:0] ENC_GATED   = 3'd3;
  localparam logic [2:0] ENC_WAKE    = 3'd4;
  localparam logic [2:0] ENC_CANCEL  = 3'd5;

  typedef enum logic [2:0] {
    ST_RUN     = ENC_RUN,
    ST_WIC_REQ = ENC_WIC_REQ,
    ST_HOLD    = ENC_HOLD,
    ST_GATED   = ENC_GATED,
    ST_WAKE    = ENC_WAKE,
    ST_CANCEL  = ENC_CANCEL
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_SYSRST = 2'b01;
  localparam logic [1:0] CAUSE_WDOG   = 2'b10;
  localparam logic [1:0] CAUSE_LOCKUP = 2'b11;

  typedef struct packed {
    logic gclk_en;
    logic sleephold_req_n;
    logic wic_en_req;
  } fsm_out_t;

  function automatic fsm_out_t state_outputs(input state_t s);
    fsm_out_t o;
    o = '{gclk_en: 1'b1, sleephold_req_n: 1'b1, wic_en_req: 1'b0};
    case (s)
      ST_WIC_REQ: o.wic_en_req = 1'b1;
      ST_HOLD: begin
        o.sleephold_req_n = 1'b0;
        o.wic_en_req      = 1'b1;
      end
      ST_GATED: begin
        o.gclk_en         = 1'b0;
        o.sleephold_req_n = 1'b0;
        o.wic_en_req      = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/aha_reset_pulse_stretch.sv
// Turns SYSRESETREQ / watchdog edges and sustained lockup into a fixed-width,
// retriggerable system reset pulse, and records the sticky cause.
module aha_reset_pulse_stretch
  import aha_sleep_ctrl_pkg::*;
#(
  parameter int unsigned LOCKUP_CYCLES    = 16,
  parameter int unsigned RST_PULSE_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sysresetreq,
  input  logic       i_wdog_reset_req,
  input  logic       i_lockup,
  input  logic       i_lockup_rst_en,
  output logic       o_sys_reset_req,
  output logic [1:0] o_reset_cause
);

  localparam cnt_t LOCKUP_MAX  = cnt_t'(LOCKUP_CYCLES);
  localparam cnt_t LOCKUP_LAST = cnt_t'(LOCKUP_CYCLES - 1);
  localparam cnt_t PULSE_LOAD  = cnt_t'(RST_PULSE_CYCLES);

  logic       r_sysrst_q;
  logic       r_wdog_q;
  cnt_t       r_lockup_cnt;
  cnt_t       r_pulse_cnt;
  logic       r_pulse_start;
  logic       r_sys_reset_req;
  logic [1:0] r_reset_cause;

  logic       w_sys_rise;
  logic       w_wdog_rise;
  logic       w_lockup_trig;
  logic       w_trig;
  cnt_t       w_pulse_next;
  logic [1:0] w_cause_next;

  assign w_sys_rise    = i_sysresetreq & ~r_sysrst_q;
  assign w_wdog_rise   = i_wdog_reset_req & ~r_wdog_q;
  // Fires on the increment that reaches the limit, not while saturated.
  assign w_lockup_trig = i_lockup & i_lockup_rst_en & (r_lockup_cnt == LOCKUP_LAST);
  assign w_trig        = w_sys_rise | w_wdog_rise | w_lockup_trig;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_pulse_next = '0;
    w_cause_next = r_reset_cause;
    if (w_trig)                 w_pulse_next = PULSE_LOAD;
    else if (r_pulse_cnt != '0) w_pulse_next = r_pulse_cnt - 1'b1;
    if (w_lockup_trig)          w_cause_next = CAUSE_LOCKUP;
    else if (w_wdog_rise)       w_cause_next = CAUSE_WDOG;
    else if (w_sys_rise)        w_cause_next = CAUSE_SYSRST;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sysrst_q      <= 1'b0;
      r_wdog_q        <= 1'b0;
      r_lockup_cnt    <= '0;
      r_pulse_cnt     <= '0;
      r_pulse_start   <= 1'b0;
      r_sys_reset_req <= 1'b0;
      r_reset_cause   <= CAUSE_NONE;
    end else begin
      r_sysrst_q      <= i_sysresetreq;
      r_wdog_q        <= i_wdog_reset_req;
      r_pulse_cnt     <= w_pulse_next;
      r_pulse_start   <= w_trig;
      r_sys_reset_req <= (w_pulse_next != '0);
      r_reset_cause   <= w_cause_next;
      if (!i_lockup || r_pulse_start)
        r_lockup_cnt <= '0;
      else if (i_lockup_rst_en && (r_lockup_cnt != LOCKUP_MAX))
        r_lockup_cnt <= r_lockup_cnt + 1'b1;
    end
  end

  assign o_sys_reset_req = r_sys_reset_req;
  assign o_reset_cause   = r_reset_cause;

endmodule

// File: rtl/aha_sleep_controller.sv
// Deep-sleep handshake sequencer (WIC enable, sleep hold, CPU clock gating)
// combined with the system reset pulse generator.
module aha_sleep_controller
  import aha_sleep_ctrl_pkg::*;
#(
  parameter int unsigned LOCKUP_CYCLES    = 16,
  parameter int unsigned RST_PULSE_CYCLES = 8,
  parameter int unsigned ACK_TIMEOUT      = 64
) (
  input  logic       MASTER_CLK,
  input  logic       PORESETn,
  input  logic       SLEEPING,
  input  logic       SLEEPDEEP,
  input  logic       SLEEPHOLDACKn,
  input  logic       PMU_WIC_EN_ACK,
  input  logic       PMU_WAKEUP,
  input  logic       LOCKUP,
  input  logic       SYSRESETREQ,
  input  logic       WDOG_RESET_REQ,
  input  logic       DBGPWRUPREQ,
  input  logic       LOCKUP_RST_EN,
  output logic       SLEEPHOLDREQn,
  output logic       PMU_WIC_EN_REQ,
  output logic       GCLK_EN,
  output logic       SYS_RESET_REQ,
  output logic [1:0] RESET_CAUSE
);

  localparam cnt_t ACK_LAST = cnt_t'(ACK_TIMEOUT - 1);

  state_t   r_state;
  cnt_t     r_ack_cnt;
  logic     r_gclk_en;
  logic     r_sleephold_req_n;
  logic     r_wic_en_req;

  state_t   w_state_next;
  fsm_out_t w_outs;
  logic     w_ack_timeout;
  logic     w_sys_reset_req;

  aha_reset_pulse_stretch #(
    .LOCKUP_CYCLES   (LOCKUP_CYCLES),
    .RST_PULSE_CYCLES(RST_PULSE_CYCLES)
  ) u_pulse (
    .i_clk           (MASTER_CLK),
    .i_rst_n         (PORESETn),
    .i_sysresetreq   (SYSRESETREQ),
    .i_wdog_reset_req(WDOG_RESET_REQ),
    .i_lockup        (LOCKUP),
    .i_lockup_rst_en (LOCKUP_RST_EN),
    .o_sys_reset_req (w_sys_reset_req),
    .o_reset_cause   (RESET_CAUSE)
  );

  // r_ack_cnt holds the number of WIC_REQ cycles already completed.
  assign w_ack_timeout = (r_ack_cnt == ACK_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:
        if (SLEEPING && SLEEPDEEP && !DBGPWRUPREQ) w_state_next = ST_WIC_REQ;
      ST_WIC_REQ:
        if (PMU_WIC_EN_ACK)                        w_state_next = ST_HOLD;
        else if (!SLEEPING || w_ack_timeout)       w_state_next = ST_CANCEL;
      ST_HOLD:
        if (PMU_WAKEUP || !SLEEPING)               w_state_next = ST_WAKE;
        else if (!SLEEPHOLDACKn)                   w_state_next = ST_GATED;
      ST_GATED:
        if (PMU_WAKEUP || DBGPWRUPREQ)             w_state_next = ST_WAKE;
      ST_WAKE, ST_CANCEL:
        if (!PMU_WIC_EN_ACK)                       w_state_next = ST_RUN;
      default:                                     w_state_next = ST_RUN;
    endcase
    if (w_sys_reset_req) w_state_next = ST_WAKE;
    w_outs = state_outputs(w_state_next);
  end

  // NOTE: async reset sets GCLK_EN high at once, so a reset during GATED ungates the clock without an edge.
  always_ff @(posedge MASTER_CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      r_state           <= ST_RUN;
      r_ack_cnt         <= '0;
      r_gclk_en         <= 1'b1;
      r_sleephold_req_n <= 1'b1;
      r_wic_en_req      <= 1'b0;
    end else begin
      r_state           <= w_state_next;
      r_gclk_en         <= w_outs.gclk_en;
      r_sleephold_req_n <= w_outs.sleephold_req_n;
      r_wic_en_req      <= w_outs.wic_en_req;
      if (r_state != ST_WIC_REQ)
        r_ack_cnt <= '0;
      else if (r_ack_cnt != '1)
        r_ack_cnt <= r_ack_cnt + 1'b1;
    end
  end

  assign GCLK_EN        = r_gclk_en;
  assign SLEEPHOLDREQn  = r_sleephold_req_n;
  assign PMU_WIC_EN_REQ = r_wic_en_req;
  assign SYS_RESET_REQ  = w_sys_reset_req;

endmodule
